// File: rtl/packet_assembler_if.sv
// packet_assembler_if: byte-stream input and 152-bit packet output handshakes for packet_assembler.
interface packet_assembler_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [151:0] packet;
    logic         pkt_valid;
    logic         pkt_ready;
    modport master (output in_data, in_valid, pkt_ready, input in_ready, packet, pkt_valid);
    modport slave  (input in_data, in_valid, pkt_ready, output in_ready, packet, pkt_valid);
endinterface

// File: rtl/packet_assembler.sv
// packet_assembler: sync hunt, 19-byte frame collection, XOR checksum check, packet handoff.
// Optional inter-byte gap timeout enabled by defining PACKET_ASSEMBLER_TIMEOUT_EN.
module packet_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         FRAME_BYTES    = 19,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter int         CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    packet_assembler_if.slave    bus,
    output logic                 err_pulse,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int LAST = FRAME_BYTES - 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [151:0]       packet_q, packet_d;
    logic [4:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic               pkt_valid_q, pkt_valid_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               accept;
    logic [7:0]         lsb;

    assign bus.in_ready  = (state_q != HOLD);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.packet    = packet_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign err_pulse     = err_pulse_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_timeout_q, err_timeout_d;
    assign err_timeout = err_timeout_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        packet_d    = packet_q;
        byte_cnt_d  = byte_cnt_q;
        chk_d       = chk_q;
        pkt_valid_d = pkt_valid_q;
        err_pulse_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        lsb         = 8'(8 * (LAST - int'(byte_cnt_q)));
`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
        gap_d         = '0;
        err_timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept && bus.in_data == SYNC_BYTE) begin
                    packet_d[151:144] = bus.in_data;
                    chk_d             = SYNC_BYTE;
                    byte_cnt_d        = 5'd1;
                    state_d           = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    packet_d[lsb +: 8] = bus.in_data;
                    if (byte_cnt_q == 5'(LAST)) begin
                        byte_cnt_d = '0;
                        if (bus.in_data == chk_q) begin
                            state_d     = HOLD;
                            pkt_valid_d = 1'b1;
                            frame_cnt_d = &frame_cnt_q ? frame_cnt_q : frame_cnt_q + 1'b1;
                        end else begin
                            state_d     = IDLE;
                            err_pulse_d = 1'b1;
                            err_cnt_d   = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
                        end
                    end else begin
                        chk_d      = chk_q ^ bus.in_data;
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
                // an accepted byte on the limit cycle takes priority over the timeout
                else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    byte_cnt_d    = '0;
                    err_pulse_d   = 1'b1;
                    err_timeout_d = 1'b1;
                    err_cnt_d     = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (bus.pkt_ready) begin
                    pkt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            packet_q    <= '0;
            byte_cnt_q  <= '0;
            chk_q       <= '0;
            pkt_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            packet_q    <= packet_d;
            byte_cnt_q  <= byte_cnt_d;
            chk_q       <= chk_d;
            pkt_valid_q <= pkt_valid_d;
            err_pulse_q <= err_pulse_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            gap_q         <= gap_d;
            err_timeout_q <= err_timeout_d;
        end
    end
`endif

endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
Byte-serial front end for the 64-bit carry-lookahead adder datapath. It hunts for a sync byte, collects a 19-byte frame, verifies an XOR checksum and presents the 152-bit packet the adder consumes, using valid/ready on both sides. Packet layout:
- [151:144] sync
- [143:136] opcode/tag
- [135:72] operand A
- [71:8] operand B
- [7:0] checksum

Parameters:
- SYNC_BYTE, 8'hA5, value that opens a frame.
- FRAME_BYTES, 19, bytes per frame. Fixed: 152/8, must not be overridden.
- TIMEOUT_CYCLES, 255, maximum idle cycles between accepted bytes inside a frame. Used only with TIMEOUT_EN.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- packet  out  152  assembled frame, first byte in [151:144].
- pkt_valid  out  1  packet is valid and checksum-clean.
- pkt_ready  in  1  downstream adder stage takes packet.
- err_pulse  out  1  one-cycle pulse when a frame is dropped.
- err_timeout  out  1  qualifies err_pulse: 1 means the drop was a timeout.
- frame_cnt  out  CNT_W  good frames delivered, saturating.
- err_cnt  out  CNT_W  frames dropped, saturating.

Behaviour:
- Reset (async assert, sync deassert sampled on clk):
  - state=IDLE; packet=0; byte_cnt=0; chk=0.
  - pkt_valid=0; err_pulse=0; err_timeout=0; frame_cnt=0; err_cnt=0.
- Byte accept occurs on a rising edge with in_valid && in_ready.
- in_ready is combinational: 1 in IDLE and COLLECT, 0 in HOLD (including the HOLD handshake cycle).
- IDLE:
  - Accepted byte == SYNC_BYTE: store it in [151:144], chk<=SYNC_BYTE, byte_cnt<=1, go to COLLECT.
  - Any other byte: discard, no error.
- COLLECT:
  - Byte index n (1..17): written to packet[151-8n -: 8]; chk<=chk^byte; byte_cnt++.
  - Index 18 (checksum byte): written to [7:0].
    - byte==chk: go to HOLD; pkt_valid=1 on the next cycle; frame_cnt++.
    - Mismatch: go to IDLE; err_pulse=1 on the next cycle for exactly one cycle, err_timeout=0; err_cnt++.
  - A byte equal to SYNC_BYTE mid-frame is plain data; there is no resync.
- HOLD:
  - packet and pkt_valid stay stable until pkt_ready.
  - On pkt_valid && pkt_ready: pkt_valid=0 next cycle, go to IDLE.
  - packet keeps its last value; it is not cleared.
- Latency: pkt_valid rises 1 cycle after the checksum byte is accepted. Back-to-back frames need one IDLE-accepted sync byte after the HOLD release.
- Counters saturate at all-ones and never wrap. frame_cnt and err_cnt never increment in the same cycle.
- Reset asserted mid-frame or in HOLD: immediate return to the reset values. The partial frame is lost and not counted.
- Checksum = XOR of bytes 0..17, compared against byte 18.

Optional Feature:
- Macro: PACKET_ASSEMBLER_TIMEOUT_EN.
- Defined:
  - In COLLECT, a gap counter clears on every accepted byte and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, err_pulse=1 and err_timeout=1 for one cycle, err_cnt++.
  - The counter is held at 0 outside COLLECT.
  - A byte accepted in the same cycle the limit is reached wins: the counter clears, no timeout.
- Not defined: no gap counter, err_timeout tied 0, a frame may stall indefinitely.

Test Plan:
- Good frame with no gaps: A5, 00, A=0000_0000_0000_0001, B=FFFF_FFFF_FFFF_FFFF, chk A4.
  -> pkt_valid 1 cycle after the last byte; packet[135:72]=1, packet[71:8]=all-ones; frame_cnt=1.
- Same frame but checksum byte 00.
  -> single err_pulse with err_timeout=0; err_cnt=1; pkt_valid stays 0; next A5 is accepted as a new frame.
- Garbage 00,FF,3C then the good frame.
  -> garbage ignored, no err_pulse, frame delivered.
- Backpressure: pkt_ready=0 for 10 cycles while bytes are offered.
  -> in_ready=0, packet stable; after a one-cycle pkt_ready, pkt_valid=0 and in_ready=1 the next cycle.
- rst_n pulsed low after byte 9, then the good frame.
  -> outputs return to reset values asynchronously; frame_cnt=1 and err_cnt=0 at the end.
- With PACKET_ASSEMBLER_TIMEOUT_EN and TIMEOUT_CYCLES=4: stop sending after byte 5.
  -> err_pulse and err_timeout high 4 cycles after the last accept; state back to IDLE; err_cnt=1.
